// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: acts as command master for the 8-point FFT coprocessor.
// It loads one frame of complex samples from the input stream, starts the
// transform, reads the bins back and emits them on the output stream.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_LD_RE    | wait for an input sample, issue LOAD_REAL and latch imag
// S_LD_IM    | issue LOAD_IMAG for the latched imag part
// S_START    | issue START for one cycle, arm the busy-rise timer
// S_WAIT_BSY | wait for cp_busy to rise, or give up after the timeout
// S_WAIT_DN  | wait for the coprocessor to finish (busy low, ready high)
// S_RD_RE    | issue STORE_REAL for the current bin
// S_RD_IM    | issue STORE_IMAG for the current bin
// S_RD_WT    | let the read data settle, then capture it into out_*
// S_EMIT     | present the bin on the output stream until accepted
module fft_frame_sequencer #(
  parameter int DW           = 32,
  parameter int N            = 8,
  parameter int RD_LAT       = 1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
  output logic [2:0]    out_idx,
  output logic          out_last,
  output logic [2:0]    cp_cmd,
  output logic [2:0]    cp_addr,
  output logic [DW-1:0] cp_data_real,
  output logic [DW-1:0] cp_data_imag,
  input  logic [DW-1:0] cp_data_out_real,
  input  logic [DW-1:0] cp_data_out_imag,
  input  logic          cp_busy,
  input  logic          cp_ready,
  output logic          frame_done,
  output logic          timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [2:0] LAST_IDX = 3'(N - 1);

  localparam logic [2:0] CMD_IDLE       = 3'b000;
  localparam logic [2:0] CMD_LOAD_REAL  = 3'b001;
  localparam logic [2:0] CMD_LOAD_IMAG  = 3'b010;
  localparam logic [2:0] CMD_STORE_REAL = 3'b011;
  localparam logic [2:0] CMD_STORE_IMAG = 3'b100;
  localparam logic [2:0] CMD_START      = 3'b101;

  typedef enum logic [3:0] {
    S_LD_RE,
    S_LD_IM,
    S_START,
    S_WAIT_BSY,
    S_WAIT_DN,
    S_RD_RE,
    S_RD_IM,
    S_RD_WT,
    S_EMIT
  } state_t;

  state_t          r_state;
  logic [2:0]      r_idx;
  logic [DW-1:0]   r_imag;
  logic [TW-1:0]   r_tmo_cnt;
  logic [LW-1:0]   r_lat_cnt;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_real;
  logic [DW-1:0]   r_out_imag;
  logic [2:0]      r_out_idx;
  logic            r_out_last;
  logic            r_frame_done;
  logic            r_timeout_err;

  logic            w_in_ready;
  logic            w_load;
  logic [2:0]      w_cmd;
  logic [2:0]      w_addr;
  logic [DW-1:0]   w_data_real;
  logic [DW-1:0]   w_data_imag;

  // A sample is only taken while the coprocessor is idle and ready for it.
  assign w_in_ready = (r_state == S_LD_RE) && cp_ready && !cp_busy;
  assign w_load     = w_in_ready && in_valid;

  // Command bus decode; LOAD_REAL follows the input handshake in the same cycle.
  always_comb begin
    w_cmd       = CMD_IDLE;
    w_addr      = 3'd0;
    w_data_real = '0;
    w_data_imag = '0;
    case (r_state)
      S_LD_RE: begin
        if (w_load) begin
          w_cmd       = CMD_LOAD_REAL;
          w_addr      = r_idx;
          w_data_real = in_real;
        end
      end
      S_LD_IM: begin
        w_cmd       = CMD_LOAD_IMAG;
        w_addr      = r_idx;
        w_data_imag = r_imag;
      end
      S_START: w_cmd = CMD_START;
      S_RD_RE: begin
        w_cmd  = CMD_STORE_REAL;
        w_addr = r_idx;
      end
      S_RD_IM: begin
        w_cmd  = CMD_STORE_IMAG;
        w_addr = r_idx;
      end
      default: w_cmd = CMD_IDLE;
    endcase
  end

  // Frame sequencing FSM with registered stream outputs and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_LD_RE;
      r_idx         <= 3'd0;
      r_imag        <= '0;
      r_tmo_cnt     <= '0;
      r_lat_cnt     <= '0;
      r_out_valid   <= 1'b0;
      r_out_real    <= '0;
      r_out_imag    <= '0;
      r_out_idx     <= 3'd0;
      r_out_last    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_LD_RE: begin
          if (w_load) begin
            r_imag  <= in_imag;
            r_state <= S_LD_IM;
          end
        end
        S_LD_IM: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= 3'd0;
            r_state <= S_START;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_LD_RE;
          end
        end
        S_START: begin
          // Down-counter holds the cycles left before giving up; the flag is
          // registered, so it shows exactly BUSY_TIMEOUT cycles after START.
          r_tmo_cnt <= TW'(BUSY_TIMEOUT - 1);
          r_state   <= S_WAIT_BSY;
        end
        S_WAIT_BSY: begin
          if (cp_busy) begin
            r_state <= S_WAIT_DN;
          end else if (r_tmo_cnt == TW'(1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_RD_RE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
          end
        end
        S_WAIT_DN: begin
          if (!cp_busy && cp_ready) begin
            r_state <= S_RD_RE;
          end
        end
        S_RD_RE: r_state <= S_RD_IM;
        S_RD_IM: begin
          r_lat_cnt <= LW'(RD_LAT - 1);
          r_state   <= S_RD_WT;
        end
        S_RD_WT: begin
          if (r_lat_cnt == '0) begin
            r_out_real  <= cp_data_out_real;
            r_out_imag  <= cp_data_out_imag;
            r_out_idx   <= r_idx;
            r_out_last  <= (r_idx == LAST_IDX);
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_frame_done <= 1'b1;
              r_idx        <= 3'd0;
              r_state      <= S_LD_RE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_RD_RE;
            end
          end
        end
        default: r_state <= S_LD_RE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign cp_cmd       = w_cmd;
  assign cp_addr      = w_addr;
  assign cp_data_real = w_data_real;
  assign cp_data_imag = w_data_imag;
  assign out_valid    = r_out_valid;
  assign out_real     = r_out_real;
  assign out_imag     = r_out_imag;
  assign out_idx      = r_out_idx;
  assign out_last     = r_out_last;
  assign frame_done   = r_frame_done;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: directed bench with a small behavioural coprocessor.
module tb_fft_frame_sequencer;

  localparam logic [2:0] C_IDLE = 3'b000;
  localparam logic [2:0] C_LR   = 3'b001;
  localparam logic [2:0] C_LI   = 3'b010;
  localparam logic [2:0] C_SR   = 3'b011;
  localparam logic [2:0] C_SI   = 3'b100;
  localparam logic [2:0] C_ST   = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_real;
  logic [31:0] in_imag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_real;
  logic [31:0] out_imag;
  logic [2:0]  out_idx;
  logic        out_last;
  logic [2:0]  cp_cmd;
  logic [2:0]  cp_addr;
  logic [31:0] cp_data_real;
  logic [31:0] cp_data_imag;
  logic [31:0] cp_data_out_real;
  logic [31:0] cp_data_out_imag;
  logic        cp_busy;
  logic        cp_ready;
  logic        frame_done;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  fft_frame_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_real          (in_real),
    .in_imag          (in_imag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_real         (out_real),
    .out_imag         (out_imag),
    .out_idx          (out_idx),
    .out_last         (out_last),
    .cp_cmd           (cp_cmd),
    .cp_addr          (cp_addr),
    .cp_data_real     (cp_data_real),
    .cp_data_imag     (cp_data_imag),
    .cp_data_out_real (cp_data_out_real),
    .cp_data_out_imag (cp_data_out_imag),
    .cp_busy          (cp_busy),
    .cp_ready         (cp_ready),
    .frame_done       (frame_done),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  // Coprocessor model: stores loads, returns re+1000 / im+2000 on reads,
  // and stays busy for 20 cycles after START when enabled.
  logic        m_busy_en;
  logic        m_ready_en;
  logic [31:0] mem_re [8];
  logic [31:0] mem_im [8];
  logic [31:0] dout_re = '0;
  logic [31:0] dout_im = '0;
  int          busy_cnt = 0;
  int          n_start  = 0;
  int          n_st_re  = 0;
  int          n_st_im  = 0;

  assign cp_busy          = (busy_cnt != 0);
  assign cp_ready         = m_ready_en && !cp_busy;
  assign cp_data_out_real = dout_re;
  assign cp_data_out_imag = dout_im;

  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    case (cp_cmd)
      C_LR: mem_re[cp_addr] <= cp_data_real;
      C_LI: mem_im[cp_addr] <= cp_data_imag;
      C_SR: begin
        dout_re <= mem_re[cp_addr] + 32'd1000;
        n_st_re <= n_st_re + 1;
      end
      C_SI: begin
        dout_im <= mem_im[cp_addr] + 32'd2000;
        n_st_im <= n_st_im + 1;
      end
      C_ST: begin
        n_start <= n_start + 1;
        if (m_busy_en) busy_cnt <= 20;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Feeds samples re=base+k, im=-(base+k); every cycle the command bus must be
  // LOAD_REAL on a handshake, LOAD_IMAG right after it, and IDLE otherwise.
  task automatic load_frame(input int base, input bit gap);
    int  k;
    int  cyc;
    bit  pend_im;
    k = 0; cyc = 0; pend_im = 0;
    while ((k < 8 || pend_im) && cyc < 300) begin
      @(negedge clk);
      in_valid = gap ? ((cyc % 2) == 1) : 1'b1;
      in_real  = 32'(base + k);
      in_imag  = 32'(-(base + k));
      #1;
      if (pend_im) begin
        chk("ld_im_cmd", 32'(cp_cmd), 32'(C_LI));
        chk("ld_im_addr", 32'(cp_addr), 32'(k - 1));
        chk("ld_im_data", cp_data_imag, 32'(-(base + k - 1)));
        chk("ld_im_in_ready", 32'(in_ready), 32'd0);
        pend_im = 0;
      end else if (in_valid && in_ready) begin
        chk("ld_re_cmd", 32'(cp_cmd), 32'(C_LR));
        chk("ld_re_addr", 32'(cp_addr), 32'(k));
        chk("ld_re_data", cp_data_real, 32'(base + k));
        pend_im = 1;
        k++;
      end else begin
        chk("ld_idle_cmd", 32'(cp_cmd), 32'(C_IDLE));
      end
      cyc++;
    end
    chk("ld_budget", 32'(cyc < 300), 32'd1);
    in_valid = 1'b0;
  endtask

  // Collects 8 bins; optionally withholds out_ready on one bin.
  task automatic read_frame(input int base, input int stall_bin);
    int b;
    int cyc;
    int sr0;
    int si0;
    b = 0; cyc = 0; sr0 = n_st_re; si0 = n_st_im;
    out_ready = 1'b1;
    while (b < 8 && cyc < 600) begin
      @(negedge clk); #1;
      cyc++;
      if (out_valid) begin
        chk("out_real", out_real, 32'(1000 + base + b));
        chk("out_imag", out_imag, 32'(2000 - base - b));
        chk("out_idx", 32'(out_idx), 32'(b));
        chk("out_last", 32'(out_last), 32'(b == 7));
        if (b == stall_bin) begin
          out_ready = 1'b0;
          repeat (5) begin
            @(negedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_real", out_real, 32'(1000 + base + b));
            chk("stall_imag", out_imag, 32'(2000 - base - b));
            chk("stall_idx", 32'(out_idx), 32'(b));
            chk("stall_cmd", 32'(cp_cmd), 32'(C_IDLE));
          end
          out_ready = 1'b1;
        end
        b++;
        if (b == 8) begin
          @(negedge clk); #1;
          chk("frame_done_pulse", 32'(frame_done), 32'd1);
          chk("out_valid_clear", 32'(out_valid), 32'd0);
          @(negedge clk); #1;
          chk("frame_done_single", 32'(frame_done), 32'd0);
        end
      end
    end
    chk("rd_budget", 32'(cyc < 600), 32'd1);
    chk("store_real_count", 32'(n_st_re - sr0), 32'd8);
    chk("store_imag_count", 32'(n_st_im - si0), 32'd8);
  endtask

  initial begin
    int s0;
    rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
    out_ready = 1'b0; m_busy_en = 1'b1; m_ready_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd", 32'(cp_cmd), 32'(C_IDLE));
    chk("rst_addr", 32'(cp_addr), 32'd0);
    chk("rst_data_real", cp_data_real, 32'd0);
    chk("rst_data_imag", cp_data_imag, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_real", out_real, 32'd0);
    chk("rst_out_imag", out_imag, 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // Coprocessor not ready: no sample accepted, no command issued.
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'b1; in_real = 32'd77; in_imag = 32'd88;
      #1;
      chk("nrdy_in_ready", 32'(in_ready), 32'd0);
      chk("nrdy_cmd", 32'(cp_cmd), 32'(C_IDLE));
    end
    in_valid = 1'b0;
    m_ready_en = 1'b1;

    // Frame 1: continuous input, re=k, im=-k.
    s0 = n_start;
    load_frame(0, 1'b0);
    @(negedge clk); #1;
    chk("f1_start_cmd", 32'(cp_cmd), 32'(C_ST));
    read_frame(0, 8);
    chk("f1_start_count", 32'(n_start - s0), 32'd1);
    chk("f1_timeout", 32'(timeout_err), 32'd0);

    // Frame 2: gapped input and a stall at bin 3.
    s0 = n_start;
    load_frame(16, 1'b1);
    @(negedge clk); #1;
    chk("f2_start_cmd", 32'(cp_cmd), 32'(C_ST));
    read_frame(16, 3);
    chk("f2_start_count", 32'(n_start - s0), 32'd1);

    // Frame 3: coprocessor never goes busy.
    m_busy_en = 1'b0;
    load_frame(32, 1'b0);
    @(negedge clk); #1;
    chk("f3_start_cmd", 32'(cp_cmd), 32'(C_ST));
    repeat (14) @(negedge clk);
    @(negedge clk); #1;
    chk("f3_timeout_early", 32'(timeout_err), 32'd0);
    @(negedge clk); #1;
    chk("f3_timeout_set", 32'(timeout_err), 32'd1);
    chk("f3_first_store", 32'(cp_cmd), 32'(C_SR));
    chk("f3_first_addr", 32'(cp_addr), 32'd0);
    read_frame(32, 8);
    chk("f3_timeout_sticky", 32'(timeout_err), 32'd1);
    m_busy_en = 1'b1;

    // Frame 4: reset while waiting for the transform to finish.
    load_frame(48, 1'b0);
    @(negedge clk); #1;
    chk("f4_start_cmd", 32'(cp_cmd), 32'(C_ST));
    repeat (5) @(negedge clk);
    #1;
    chk("f4_busy_before_rst", 32'(cp_busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_cmd", 32'(cp_cmd), 32'(C_IDLE));
    chk("mrst_addr", 32'(cp_addr), 32'd0);
    chk("mrst_data_real", cp_data_real, 32'd0);
    chk("mrst_data_imag", cp_data_imag, 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_real", out_real, 32'd0);
    chk("mrst_out_imag", out_imag, 32'd0);
    chk("mrst_out_idx", 32'(out_idx), 32'd0);
    chk("mrst_out_last", 32'(out_last), 32'd0);
    chk("mrst_frame_done", 32'(frame_done), 32'd0);
    chk("mrst_timeout", 32'(timeout_err), 32'd0);

    // Frame 5: fresh frame after the abandoned one starts at address 0.
    s0 = n_start;
    load_frame(64, 1'b0);
    @(negedge clk); #1;
    chk("f5_start_cmd", 32'(cp_cmd), 32'(C_ST));
    read_frame(64, 8);
    chk("f5_start_count", 32'(n_start - s0), 32'd1);
    chk("f5_timeout", 32'(timeout_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Upstream/downstream driver for the 8-point FFT coprocessor command interface.
- Accepts a valid/ready stream of complex samples and loads 8 of them into the coprocessor buffer with LOAD_REAL/LOAD_IMAG pairs.
- Issues START, waits for the computation to finish, then reads the 8 results back with STORE_REAL/STORE_IMAG.
- Emits the results as a valid/ready output stream with a last-flag. Replaces the CPU as the coprocessor's command master for streaming use.

Parameters:
- DW, 32, sample/result component width (matches coprocessor data ports).
- N, 8, points per frame; address width is log2(N) = 3.
- RD_LAT, 1, idle cycles inserted after STORE_IMAG before capturing cp_data_out_*.
- BUSY_TIMEOUT, 16, max cycles after START to wait for cp_busy rise.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer accepts sample this cycle.
- in_real  in  DW  input real part.
- in_imag  in  DW  input imag part.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_real  out  DW  result real part.
- out_imag  out  DW  result imag part.
- out_idx  out  3  result bin index.
- out_last  out  1  high with bin 7.
- cp_cmd  out  3  coprocessor command: 000 IDLE, 001 LOAD_REAL, 010 LOAD_IMAG, 011 STORE_REAL, 100 STORE_IMAG, 101 START.
- cp_addr  out  3  coprocessor sample address.
- cp_data_real  out  DW  coprocessor data_in_real.
- cp_data_imag  out  DW  coprocessor data_in_imag.
- cp_data_out_real  in  DW  coprocessor data_out_real.
- cp_data_out_imag  in  DW  coprocessor data_out_imag.
- cp_busy  in  1  coprocessor busy.
- cp_ready  in  1  coprocessor ready.
- frame_done  out  1  one-cycle pulse after bin 7 handshake.
- timeout_err  out  1  sticky; set when cp_busy never rises after START.

Behaviour:
- Reset (rst sampled high at posedge):
  - state=LD_RE, idx=0.
  - Outputs: cp_cmd=IDLE, cp_addr=0, cp_data_*=0, in_ready=0, out_valid=0, out_real/imag=0, out_idx=0, out_last=0, frame_done=0, timeout_err=0.
  - Reset mid-frame abandons the frame; partial data left in the coprocessor is overwritten by the next frame.
- cp_cmd, cp_addr and cp_data_imag decode from registered state/idx/latched imag. cp_data_real passes in_real straight through in LD_RE.
- States:
  - LD_RE:
    - in_ready = cp_ready & !cp_busy.
    - If in_valid & in_ready: cp_cmd=LOAD_REAL, cp_addr=idx, cp_data_real=in_real; latch in_imag; go to LD_IM.
    - Otherwise cp_cmd=IDLE.
  - LD_IM: cp_cmd=LOAD_IMAG, cp_addr=idx, cp_data_imag=latched imag. If idx==7 go to START with idx=0; else idx+1 and back to LD_RE.
    - Each sample takes exactly 2 cycles; in_ready is low in LD_IM.
  - START: cp_cmd=START for 1 cycle; clear the timeout counter; go to WAIT_BSY.
  - WAIT_BSY:
    - cp_cmd=IDLE. When cp_busy=1, go to WAIT_DN.
    - If the counter reaches BUSY_TIMEOUT, set timeout_err and go to RD_RE (best-effort readback).
  - WAIT_DN: when cp_busy=0 and cp_ready=1, go to RD_RE.
  - RD_RE: cp_cmd=STORE_REAL, cp_addr=idx; go to RD_IM.
  - RD_IM: cp_cmd=STORE_IMAG, cp_addr=idx; go to RD_WT.
  - RD_WT: cp_cmd=IDLE, held RD_LAT cycles; then capture cp_data_out_real/imag into out_real/imag, set out_valid, out_idx=idx, out_last=(idx==7); go to EMIT.
  - EMIT:
    - Hold all out_* stable while out_valid & !out_ready.
    - On handshake: out_valid=0.
    - If idx==7: frame_done=1 for one cycle, idx=0, go to LD_RE.
    - Otherwise idx+1 and go to RD_RE.
- No new input is accepted until the whole frame has drained. Back-pressure on out_ready stalls readback indefinitely with no data loss.
- timeout_err clears only on rst.
- idx is a 3-bit counter; wrap from 7 is explicit through the state transitions, never implicit.

Test Plan:
- Load samples re=k, im=-k (k=0..7) with in_valid held high, and a coprocessor model that returns out[k] = re+1000, im+2000 after busy pulses for 20 cycles. Required: 16 load cycles with cp_addr 0,0,1,1,…7,7; a single START; 8 outputs (1000+k, 2000-k) with out_idx 0..7; out_last only at 7; frame_done pulses once.
- Gap input (in_valid toggling every other cycle). Required: the LOAD_REAL/LOAD_IMAG pairs stay adjacent; there is no LOAD_REAL without a following LOAD_IMAG.
- out_ready low for 5 cycles at bin 3. Required: out_real/imag/idx stay stable; there are no extra STORE commands; bin 4 follows after release.
- Model never raises cp_busy. Required: timeout_err=1 exactly 16 cycles after START; readback still yields 8 outputs.
- rst pulsed during WAIT_DN. Required: next cycle all outputs equal their reset values; the next frame starts at cp_addr 0.
- cp_ready=0 while in LD_RE. Required: in_ready=0 and no commands are issued until cp_ready returns to 1.
